// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - request size encodings, FSM states and lane-mask helper for dmem_lsu
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << lane;
      SZ_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous 32-bit RAM with per-byte write enables
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // rdata only moves on an enabled access, so it holds the last read while the LSU waits
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit over dmem_array; optional DMEM_LSU_BOUNDS_CHECK_EN rejects addresses >= 4*DEPTH
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(DEPTH);

  state_e        state, state_nx;
  logic [3:0]    cnt;
  logic          we_q, uns_q, err_q;
  logic [1:0]    size_q, lane_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;

  logic          accept, commit, bad_align, oob;
  logic [31:0]   ram_wdata, ram_q, load_v;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;
  assign commit     = (state == ACCESS) && (cnt == 4'd0);

  always_comb begin
    bad_align = 1'b0;
    case (req_size)
      SZ_HALF: bad_align = req_addr[0];
      SZ_WORD: bad_align = |req_addr[1:0];
      SZ_RSVD: bad_align = 1'b1;
      default: bad_align = 1'b0;
    endcase
  end

`ifdef DMEM_LSU_BOUNDS_CHECK_EN
  assign oob = |req_addr[ADDR_W-1:AW+2];
`else
  // upper address bits are dropped so accesses wrap modulo the array size
  logic unused_addr_hi;
  assign unused_addr_hi = |req_addr[ADDR_W-1:AW+2];
  assign oob = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      lane_q  <= 2'b00;
      idx_q   <= '0;
      wdata_q <= 32'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt     <= 4'(WAIT_CYCLES);
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= bad_align || oob;
        size_q  <= req_size;
        lane_q  <= req_addr[1:0];
        idx_q   <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
      end else if ((state == ACCESS) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    case (size_q)
      SZ_BYTE: ram_wdata = {4{wdata_q[7:0]}};
      SZ_HALF: ram_wdata = {2{wdata_q[15:0]}};
      default: ram_wdata = wdata_q;
    endcase
  end

  // a rejected request still walks the FSM but never touches the array
  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .en    (commit && !err_q),
    .we    (we_q),
    .be    (lane_mask(size_q, lane_q)),
    .addr  (idx_q),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  assign byte_v = 8'(ram_q >> {lane_q, 3'b000});
  assign half_v = lane_q[1] ? ram_q[31:16] : ram_q[15:0];

  always_comb begin
    case (size_q)
      SZ_BYTE: load_v = {{24{~uns_q & byte_v[7]}}, byte_v};
      SZ_HALF: load_v = {{16{~uns_q & half_v[15]}}, half_v};
      default: load_v = ram_q;
    endcase
  end

  assign resp_rdata = (resp_valid && !we_q && !err_q) ? load_v : 32'd0;
  assign resp_err   = resp_valid && err_q;

endmodule
